frame_out_stage: RTL and testbench
==================================

FRAME_OUT_STAGE -- requirements
Module: frame_out_stage

Interface
REQ-001 Parameter DW, default 8, data width of memory word and output word.
REQ-002 Parameter AW, default 8, read-address width.
REQ-003 Parameter FRAME_LEN, default 188, words per frame; legal range 1..2^AW.
REQ-004 Parameter CE_DIV, default 8, clocks per output strobe; legal range 2..256.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 DONE  in  1  one-clock pulse, frame ready in the write-side bank.
REQ-008 clr_ovr  in  1  one-clock pulse, clears overrun.
REQ-009 RE  out  1  ping-pong bank select for the input memories; toggles once per accepted frame.
REQ-010 RdAdd  out  AW  read address to the input memories.
REQ-011 In_byte  in  DW  memory read data; valid one clk after RdAdd changes (sync RAM).
REQ-012 Out_byte  out  DW  output word, held for a full CE period.
REQ-013 CEO  out  1  output strobe, CE delayed one clk.
REQ-014 Valid_out  out  1  Out_byte carries frame data.
REQ-015 out_done  out  1  one-clock pulse, last word of frame issued.
REQ-016 busy  out  1  high in ARMED or RUN.
REQ-017 overrun  out  1  sticky, DONE lost.

Function
REQ-018 Internal counter cnt wraps 0..CE_DIV-1; internal CE SHALL be high exactly one clk per CE_DIV clks, first on the CE_DIV-th rising edge after reset release.
REQ-019 CEO SHALL equal CE delayed by one clk, free-running irrespective of state.
REQ-020 FSM states SHALL be IDLE, ARMED, RUN; reset state IDLE.
REQ-021 IDLE: on DONE, RE SHALL toggle, RdAdd SHALL load 0, next state ARMED.
REQ-022 ARMED: on CE, next state RUN; no word issued on that CE.
REQ-023 RUN, each CE: Out_byte <= In_byte, Valid_out <= 1; if RdAdd == FRAME_LEN-1 then out_done pulses next clk and state leaves RUN, else RdAdd increments by 1.
REQ-024 IDLE or ARMED, each CE: Valid_out SHALL drop to 0; Out_byte holds its last value.
REQ-025 Latency: first word on the second CE after DONE; frame occupies exactly FRAME_LEN consecutive CEs in RUN.
REQ-026 DONE while busy SHALL set a one-deep pending flag; DONE while pending already set SHALL set overrun and be discarded.
REQ-027 At end of frame with pending set: clear pending, toggle RE, RdAdd <= 0, go ARMED; else go IDLE.
REQ-028 DONE in the same clk as the end-of-frame CE SHALL be treated as pending (restart, no overrun).
REQ-029 DONE in IDLE coincident with CE SHALL enter ARMED only; ARMED->RUN waits for the next CE.
REQ-030 overrun SHALL clear on clr_ovr; a coincident new overrun event SHALL win (stays 1).
REQ-031 RdAdd arithmetic SHALL be AW bits, never exceeding FRAME_LEN-1.
REQ-032 busy SHALL be combinational decode of state (ARMED or RUN).

Reset
REQ-033 Asserting reset SHALL immediately force RE=0, RdAdd=0, Out_byte=0, CEO=0, Valid_out=0, out_done=0, overrun=0, pending=0, cnt=0, CE=0, state IDLE.
REQ-034 Reset mid-frame SHALL abandon the frame with no out_done; the first DONE after release restarts at RdAdd 0 with RE toggled from 0 to 1.

Verification
REQ-035 Defaults, memory model data=address: reset release, DONE at clk 20 -> RE=1; Valid_out rises on 2nd CE after DONE; Out_byte 0..187 on consecutive CEs; one out_done pulse; busy falls after last CE.
REQ-036 DONE once mid-frame -> no overrun; second frame starts immediately, RE toggles back to 0, RdAdd restarts at 0, Valid_out stays 1 across the boundary CE.
REQ-037 Three DONE pulses during one frame -> overrun=1 after the 2nd extra DONE; clr_ovr -> overrun=0; exactly two frames output.
REQ-038 DONE coincident with the final-word CE -> back-to-back frame, overrun=0.
REQ-039 Reset asserted at word 50 -> all outputs zero asynchronously; no out_done; next DONE gives a full 188-word frame.
REQ-040 DW=12, AW=4, FRAME_LEN=16, CE_DIV=2 -> CE every 2 clks, 16 words, RdAdd max 15, out_done once.

Source files
------------

// File: rtl/frame_out_stage_if.sv
// frame_out_if: bundles the read-memory side (RE, RdAdd, In_byte) and the
// output word side (Out_byte, CEO, Valid_out, out_done) of frame_out_stage.
//   master : the frame_out_stage instance (drives RE/RdAdd and the output word)
//   slave  : the memory / downstream environment (drives In_byte)
interface frame_out_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          RE;         // ping-pong bank select
  logic [AW-1:0] RdAdd;      // read address into the selected bank
  logic [DW-1:0] In_byte;    // sync-RAM read data, one clk after RdAdd
  logic [DW-1:0] Out_byte;   // output word, held for a CE period
  logic          CEO;        // output strobe (CE delayed one clk)
  logic          Valid_out;  // Out_byte carries frame data
  logic          out_done;   // one-clk pulse with the last word of a frame

  modport master (
    output RE, RdAdd, Out_byte, CEO, Valid_out, out_done,
    input  In_byte
  );

  modport slave (
    input  RE, RdAdd, Out_byte, CEO, Valid_out, out_done,
    output In_byte
  );
endinterface

// File: rtl/frame_out_stage.sv
// frame_out_stage: reads a completed frame out of a ping-pong memory pair and
// issues it one word per output strobe.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   DONE       : one-clk pulse, a frame is ready in the write-side bank
//   clr_ovr    : one-clk pulse, clears the sticky overrun flag
//   busy       : high while ARMED or RUN
//   overrun    : sticky, a DONE had to be discarded
//   bus        : frame_out_if master (memory read port + output word)
module frame_out_stage #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int FRAME_LEN = 188,
  parameter int CE_DIV    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic DONE,
  input  logic clr_ovr,
  output logic busy,
  output logic overrun,
  frame_out_if.master bus
);

  localparam int            CW       = $clog2(CE_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CE_DIV - 1);
  localparam logic [AW-1:0] LAST_ADD = AW'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;
  logic          ceo_q;
  logic [1:0]    state_q, state_d;
  logic          re_q, re_d;
  logic [AW-1:0] rd_add_q, rd_add_d;
  logic [DW-1:0] out_byte_q, out_byte_d;
  logic          valid_q, valid_d;
  logic          out_done_q, out_done_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          ovr_set_s;

  // Strobe divider: CE is registered so it rises on the CE_DIV-th edge.
  always_comb begin
    ce_d = (cnt_q == CNT_MAX);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Frame sequencer: bank handoff, address walk, pending/overrun bookkeeping.
  always_comb begin
    state_d    = state_q;
    re_d       = re_q;
    rd_add_d   = rd_add_q;
    out_byte_d = out_byte_q;
    valid_d    = valid_q;
    out_done_d = 1'b0;
    pending_d  = pending_q;
    ovr_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A CE here only drops Valid_out; DONE arms but never starts RUN.
        if (ce_q) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        if (DONE) begin
          re_d     = ~re_q;
          rd_add_d = '0;
          state_d  = ST_ARMED;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (ce_q) begin
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARMED;
        end
        if (DONE) begin
          if (pending_q) begin
            ovr_set_s = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end else begin
          pending_d = pending_q;
        end
      end
      ST_RUN: begin
        if (ce_q && (rd_add_q == LAST_ADD)) begin
          out_byte_d = bus.In_byte;
          valid_d    = 1'b1;
          out_done_d = 1'b1;
          // A DONE arriving on the final CE counts as the next frame.
          if (pending_q || DONE) begin
            re_d      = ~re_q;
            rd_add_d  = '0;
            state_d   = ST_ARMED;
            // Pending slot is consumed; a simultaneous DONE refills it.
            pending_d = pending_q & DONE;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          if (ce_q) begin
            out_byte_d = bus.In_byte;
            valid_d    = 1'b1;
            rd_add_d   = rd_add_q + AW'(1);
          end else begin
            rd_add_d   = rd_add_q;
          end
          if (DONE) begin
            if (pending_q) begin
              ovr_set_s = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end else begin
            pending_d = pending_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A new overrun event beats a coincident clear.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      ceo_q      <= 1'b0;
      state_q    <= ST_IDLE;
      re_q       <= 1'b0;
      rd_add_q   <= '0;
      out_byte_q <= '0;
      valid_q    <= 1'b0;
      out_done_q <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      ceo_q      <= ce_q;
      state_q    <= state_d;
      re_q       <= re_d;
      rd_add_q   <= rd_add_d;
      out_byte_q <= out_byte_d;
      valid_q    <= valid_d;
      out_done_q <= out_done_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy          = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign overrun       = overrun_q;
  assign bus.RE        = re_q;
  assign bus.RdAdd     = rd_add_q;
  assign bus.Out_byte  = out_byte_q;
  assign bus.CEO       = ceo_q;
  assign bus.Valid_out = valid_q;
  assign bus.out_done  = out_done_q;

endmodule

// File: tb/tb_frame_out_stage.sv
// tb_frame_out_stage: directed bench for frame_out_stage. dut1 uses the
// default geometry (188 words, CE every 8 clks), dut2 a small one (16 words,
// CE every 2 clks). Each has a sync-RAM model returning data = address.
module tb_frame_out_stage;

  logic clk = 1'b0;
  logic reset, DONE, DONE2, clr_ovr, clr_ovr2;
  logic busy, overrun, busy2, overrun2;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  frame_out_if #(.DW(8),  .AW(8)) bus1();
  frame_out_if #(.DW(12), .AW(4)) bus2();

  frame_out_stage #(.DW(8), .AW(8), .FRAME_LEN(188), .CE_DIV(8)) dut1 (
    .clk(clk), .reset(reset), .DONE(DONE), .clr_ovr(clr_ovr),
    .busy(busy), .overrun(overrun), .bus(bus1.master)
  );

  frame_out_stage #(.DW(12), .AW(4), .FRAME_LEN(16), .CE_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .DONE(DONE2), .clr_ovr(clr_ovr2),
    .busy(busy2), .overrun(overrun2), .bus(bus2.master)
  );

  // sync RAM models: data = address, one clk after RdAdd
  always @(posedge clk) bus1.In_byte <= 8'(bus1.RdAdd);
  always @(posedge clk) bus2.In_byte <= 12'(bus2.RdAdd);

  // monitors
  int words[$];
  int words2[$];
  int ceo_cnt = 0, done_cnt = 0, first_valid_ce = 0;
  int done_cnt2 = 0, max_add2 = 0;
  bit prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus1.CEO) begin
          ceo_cnt++;
          if (bus1.Valid_out) words.push_back(int'(bus1.Out_byte));
        end
        if (bus1.Valid_out && !prev_valid) first_valid_ce = ceo_cnt;
        prev_valid = bus1.Valid_out;
        if (bus1.out_done) done_cnt++;
        if (bus2.CEO && bus2.Valid_out) words2.push_back(int'(bus2.Out_byte));
        if (bus2.out_done) done_cnt2++;
        if (int'(bus2.RdAdd) > max_add2) max_add2 = int'(bus2.RdAdd);
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // move to just after the next falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_done();
    DONE = 1'b1;
    step();
    DONE = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (words.size() < n && k < 5000) begin
      step();
      k++;
    end
    check_eq("wait_words", 32'(words.size() >= n), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    step();
    while (!bus1.out_done && k < 5000) begin
      step();
      k++;
    end
    check_eq("wait_done", 32'(bus1.out_done), 32'd1);
  endtask

  // count words not matching (i mod len)
  task automatic check_seq(input string tag, input int n, input int len);
    int bad = 0;
    check_eq({tag, "_len"}, 32'(words.size()), 32'(n));
    for (int i = 0; i < words.size(); i++) begin
      if (words[i] != (i % len)) bad++;
    end
    check_eq({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int n, m, c0, dbase;
    bit exp_re;
    reset = 1'b1; DONE = 1'b0; DONE2 = 1'b0; clr_ovr = 1'b0; clr_ovr2 = 1'b0;
    exp_re = 1'b0;
    step();
    step();
    check_eq("rst_re",       32'(bus1.RE),        32'd0);
    check_eq("rst_rdadd",    32'(bus1.RdAdd),     32'd0);
    check_eq("rst_out",      32'(bus1.Out_byte),  32'd0);
    check_eq("rst_ceo",      32'(bus1.CEO),       32'd0);
    check_eq("rst_valid",    32'(bus1.Valid_out), 32'd0);
    check_eq("rst_done",     32'(bus1.out_done),  32'd0);
    check_eq("rst_ovr",      32'(overrun),        32'd0);
    check_eq("rst_busy",     32'(busy),           32'd0);

    // strobe timing: first CE on edge 8, so CEO on edge 9; period 8
    reset = 1'b0;
    n = 0;
    while (!bus1.CEO && n < 20) begin step(); n++; end
    check_eq("first_ceo_edge", 32'(n), 32'd9);
    m = 0;
    do begin step(); m++; end while (!bus1.CEO && m < 20);
    check_eq("ceo_period", 32'(m), 32'd8);
    repeat (3) step();

    // single frame
    words.delete(); dbase = done_cnt;
    pulse_done(); exp_re = ~exp_re; c0 = ceo_cnt;
    check_eq("f1_re",    32'(bus1.RE),    32'(exp_re));
    check_eq("f1_busy",  32'(busy),       32'd1);
    check_eq("f1_rdadd", 32'(bus1.RdAdd), 32'd0);
    wait_done();
    check_eq("f1_busy_end", 32'(busy), 32'd0);
    check_seq("f1", 188, 188);
    check_eq("f1_latency", 32'(first_valid_ce), 32'(c0 + 2));
    check_eq("f1_ndone",   32'(done_cnt - dbase), 32'd1);
    repeat (10) step();
    check_eq("f1_valid_idle", 32'(bus1.Valid_out), 32'd0);
    check_eq("f1_out_hold",   32'(bus1.Out_byte),  32'd187);

    // one extra DONE mid-frame: back-to-back frames
    words.delete(); dbase = done_cnt;
    pulse_done(); exp_re = ~exp_re;
    check_eq("f2_re", 32'(bus1.RE), 32'(exp_re));
    wait_words(50);
    pulse_done();
    check_eq("f2_ovr", 32'(overrun), 32'd0);
    wait_done(); exp_re = ~exp_re;
    check_eq("f2_re_restart", 32'(bus1.RE),        32'(exp_re));
    check_eq("f2_rdadd0",     32'(bus1.RdAdd),     32'd0);
    check_eq("f2_valid_bnd",  32'(bus1.Valid_out), 32'd1);
    check_eq("f2_busy_bnd",   32'(busy),           32'd1);
    wait_done();
    check_seq("f2", 376, 188);
    check_eq("f2_ndone", 32'(done_cnt - dbase), 32'd2);

    // three extra DONEs: pending, overrun, overrun coincident with clear
    words.delete(); dbase = done_cnt;
    pulse_done(); exp_re = ~exp_re;
    wait_words(20);
    pulse_done();
    check_eq("f3_ovr_pend", 32'(overrun), 32'd0);
    wait_words(40);
    pulse_done();
    check_eq("f3_ovr_set", 32'(overrun), 32'd1);
    wait_words(60);
    clr_ovr = 1'b1;
    pulse_done();
    clr_ovr = 1'b0;
    check_eq("f3_ovr_wins", 32'(overrun), 32'd1);
    wait_done(); exp_re = ~exp_re;
    wait_done();
    repeat (30) step();
    check_eq("f3_busy_end", 32'(busy), 32'd0);
    check_seq("f3", 376, 188);
    check_eq("f3_ndone", 32'(done_cnt - dbase), 32'd2);
    check_eq("f3_re", 32'(bus1.RE), 32'(exp_re));
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    check_eq("f3_ovr_clr", 32'(overrun), 32'd0);

    // DONE coincident with the final-word CE
    words.delete(); dbase = done_cnt;
    pulse_done(); exp_re = ~exp_re;
    n = 0;
    while (bus1.RdAdd != 8'd187 && n < 5000) begin step(); n++; end
    repeat (7) step();
    pulse_done(); exp_re = ~exp_re;
    check_eq("f4_done_pulse", 32'(bus1.out_done), 32'd1);
    check_eq("f4_re",         32'(bus1.RE),       32'(exp_re));
    check_eq("f4_rdadd0",     32'(bus1.RdAdd),    32'd0);
    check_eq("f4_busy",       32'(busy),          32'd1);
    wait_done();
    check_eq("f4_ovr", 32'(overrun), 32'd0);
    check_seq("f4", 376, 188);

    // reset mid-frame (overrun and pending set beforehand)
    words.delete();
    pulse_done();
    wait_words(20);
    pulse_done();
    pulse_done();
    check_eq("f5_ovr_pre", 32'(overrun), 32'd1);
    wait_words(50);
    dbase = done_cnt;
    #2 reset = 1'b1;
    #1;
    check_eq("f5_re",    32'(bus1.RE),        32'd0);
    check_eq("f5_rdadd", 32'(bus1.RdAdd),     32'd0);
    check_eq("f5_out",   32'(bus1.Out_byte),  32'd0);
    check_eq("f5_ceo",   32'(bus1.CEO),       32'd0);
    check_eq("f5_valid", 32'(bus1.Valid_out), 32'd0);
    check_eq("f5_ovr",   32'(overrun),        32'd0);
    check_eq("f5_busy",  32'(busy),           32'd0);
    repeat (3) step();
    check_eq("f5_no_done", 32'(done_cnt - dbase), 32'd0);
    reset = 1'b0;
    words.delete();
    // DONE lands on the first CE after release: arms only
    repeat (8) step();
    pulse_done(); c0 = ceo_cnt;
    check_eq("f5_c0",     32'(c0),      32'(ceo_cnt));
    check_eq("f5_re_new", 32'(bus1.RE), 32'd1);
    wait_done();
    check_eq("f5_latency", 32'(first_valid_ce), 32'(c0 + 2));
    repeat (30) step();
    check_eq("f5_busy_end", 32'(busy), 32'd0);
    check_seq("f5", 188, 188);
    check_eq("f5_ndone", 32'(done_cnt - dbase), 32'd1);

    // small geometry instance
    words2.delete(); dbase = done_cnt2; max_add2 = 0;
    n = 0;
    while (!bus2.CEO && n < 20) begin step(); n++; end
    m = 0;
    do begin step(); m++; end while (!bus2.CEO && m < 20);
    check_eq("d2_ceo_period", 32'(m), 32'd2);
    DONE2 = 1'b1; step(); DONE2 = 1'b0;
    check_eq("d2_re", 32'(bus2.RE), 32'd1);
    n = 0;
    while (!bus2.out_done && n < 200) begin step(); n++; end
    check_eq("d2_wait_done", 32'(bus2.out_done), 32'd1);
    repeat (10) step();
    check_eq("d2_len", 32'(words2.size()), 32'd16);
    m = 0;
    for (int i = 0; i < words2.size(); i++) if (words2[i] != i) m++;
    check_eq("d2_data",    32'(m),                   32'd0);
    check_eq("d2_max_add", 32'(max_add2),            32'd15);
    check_eq("d2_ndone",   32'(done_cnt2 - dbase),   32'd1);
    check_eq("d2_busy",    32'(busy2),               32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
